// File: rtl/shift_seq_pkg.sv
// Shared types for the LED shift sequencer: shift direction, requester indices,
// auto-walk FSM states and the command held in the output register.
package shift_seq_pkg;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam int REQ_L   = 0;
    localparam int REQ_R   = 1;
    localparam int REQ_A   = 2;
    localparam int NUM_REQ = 3;

    typedef enum logic {
        AUTO_OFF = 1'b0,
        AUTO_RUN = 1'b1
    } auto_state_e;

    typedef struct packed {
        dir_e dir;
        logic val;
    } cmd_t;

    function automatic cmd_t mk_cmd(input dir_e d, input logic v);
        cmd_t c;
        c.dir = d;
        c.val = v;
        return c;
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Valid/ready command channel from the sequencer to the shift datapath.
interface shift_seq_if;
    logic cmd_valid;
    logic cmd_dir;
    logic cmd_bit;
    logic cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_bit,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_bit,
        output cmd_ready
    );
endinterface

// File: rtl/shift_seq_prescaler.sv
// Auto-walk step prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// last count with a one-cycle tick; clear_i forces the count back to zero.
module shift_seq_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    assign tick_o = enable_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/shift_sequencer.sv
// Arbitrates left push, right push and auto-walk steps into one valid/ready
// command stream. Optional macro SHIFT_SEQ_BOUNCE_EN makes the walk ping-pong.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            left_push,
    input  logic            right_push,
    input  logic            left_bit,
    input  logic            right_bit,
    input  logic            auto_en,
    output logic            overrun,
    shift_seq_if.master     cmd_if
);
    localparam int SW_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW_W-1:0] SWEEP_LAST = SW_W'(WIDTH - 1);

    // Auto-walk FSM
    auto_state_e auto_state_q, auto_state_d;
    logic        presc_en, auto_clr, auto_live;
    logic        presc_tick, tick_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_state_q <= AUTO_OFF;
        end else begin
            auto_state_q <= auto_state_d;
        end
    end

    always_comb begin
        auto_state_d = auto_state_q;
        case (auto_state_q)
            AUTO_OFF: if (auto_en)  auto_state_d = AUTO_RUN;
            AUTO_RUN: if (!auto_en) auto_state_d = AUTO_OFF;
            default:                auto_state_d = AUTO_OFF;
        endcase
    end

    // Clearing whenever the next state is OFF covers both the exit edge and idling in OFF.
    always_comb begin
        presc_en  = (auto_state_q == AUTO_RUN);
        auto_clr  = (auto_state_d == AUTO_OFF);
        auto_live = (auto_state_q == AUTO_RUN) && (auto_state_d == AUTO_RUN);
    end

    shift_seq_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (auto_clr),
        .enable_i (presc_en),
        .tick_o   (presc_tick)
    );

    assign tick_a = presc_tick && auto_live;

    // Pending requests, round-robin pointer, sweep state, output register
    logic            pend_l_q, pend_l_d, pend_r_q, pend_r_d, pend_a_q, pend_a_d;
    logic            bit_l_q, bit_l_d, bit_r_q, bit_r_d;
    logic            rr_last_r_q, rr_last_r_d;
    logic [SW_W-1:0] sweep_q, sweep_d;
    dir_e            auto_dir_q, auto_dir_d;
    logic            cmd_valid_q, cmd_valid_d;
    cmd_t            cmd_q, cmd_d;
    logic            overrun_q, overrun_d;

    logic [NUM_REQ-1:0] req, gnt;
    logic               free;
    logic               l_bit_eff, r_bit_eff;

    assign free      = !cmd_valid_q || cmd_if.cmd_ready;
    assign l_bit_eff = pend_l_q ? bit_l_q : left_bit;
    assign r_bit_eff = pend_r_q ? bit_r_q : right_bit;

    // A fresh push competes in the cycle it arrives, so an idle output loads it on the next edge.
    always_comb begin
        req        = '0;
        req[REQ_L] = pend_l_q || left_push;
        req[REQ_R] = pend_r_q || right_push;
        req[REQ_A] = auto_live && (pend_a_q || tick_a);
    end

    always_comb begin
        gnt = '0;
        if (free) begin
            if (req[REQ_L] && req[REQ_R]) begin
                if (rr_last_r_q) gnt[REQ_L] = 1'b1;
                else             gnt[REQ_R] = 1'b1;
            end else if (req[REQ_L]) begin
                gnt[REQ_L] = 1'b1;
            end else if (req[REQ_R]) begin
                gnt[REQ_R] = 1'b1;
            end else if (req[REQ_A]) begin
                gnt[REQ_A] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_last_r_d = rr_last_r_q;
        if (gnt[REQ_R])      rr_last_r_d = 1'b1;
        else if (gnt[REQ_L]) rr_last_r_d = 1'b0;
    end

    // A push landing on the cycle its pending is granted re-arms the pending.
    always_comb begin
        pend_l_d = pend_l_q ? (!gnt[REQ_L] || left_push)  : (left_push  && !gnt[REQ_L]);
        pend_r_d = pend_r_q ? (!gnt[REQ_R] || right_push) : (right_push && !gnt[REQ_R]);
        bit_l_d  = (left_push  && (!pend_l_q || gnt[REQ_L])) ? left_bit  : bit_l_q;
        bit_r_d  = (right_push && (!pend_r_q || gnt[REQ_R])) ? right_bit : bit_r_q;
        if (auto_clr) begin
            pend_a_d = 1'b0;
        end else begin
            pend_a_d = pend_a_q ? (!gnt[REQ_A] || tick_a) : (tick_a && !gnt[REQ_A]);
        end
        overrun_d = (left_push  && pend_l_q && !gnt[REQ_L])
                 || (right_push && pend_r_q && !gnt[REQ_R])
                 || (tick_a     && pend_a_q && !gnt[REQ_A]);
    end

    always_comb begin
        sweep_d    = sweep_q;
        auto_dir_d = auto_dir_q;
        if (auto_clr) begin
            sweep_d    = '0;
            auto_dir_d = DIR_LEFT;
        end else if (gnt[REQ_A]) begin
            if (sweep_q == SWEEP_LAST) begin
                sweep_d = '0;
`ifdef SHIFT_SEQ_BOUNCE_EN
                auto_dir_d = (auto_dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
`else
                auto_dir_d = DIR_LEFT;
`endif
            end else begin
                sweep_d = sweep_q + 1'b1;
            end
        end
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        if (free) begin
            cmd_valid_d = |gnt;
            if (gnt[REQ_L])      cmd_d = mk_cmd(DIR_LEFT, l_bit_eff);
            else if (gnt[REQ_R]) cmd_d = mk_cmd(DIR_RIGHT, r_bit_eff);
            else if (gnt[REQ_A]) cmd_d = mk_cmd(auto_dir_q, sweep_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_l_q    <= 1'b0;
            pend_r_q    <= 1'b0;
            pend_a_q    <= 1'b0;
            bit_l_q     <= 1'b0;
            bit_r_q     <= 1'b0;
            rr_last_r_q <= 1'b1;
            sweep_q     <= '0;
            auto_dir_q  <= DIR_LEFT;
            cmd_valid_q <= 1'b0;
            cmd_q       <= mk_cmd(DIR_LEFT, 1'b0);
            overrun_q   <= 1'b0;
        end else begin
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            pend_a_q    <= pend_a_d;
            bit_l_q     <= bit_l_d;
            bit_r_q     <= bit_r_d;
            rr_last_r_q <= rr_last_r_d;
            sweep_q     <= sweep_d;
            auto_dir_q  <= auto_dir_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_dir   = cmd_q.dir;
    assign cmd_if.cmd_bit   = cmd_q.val;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with TICK_DIV=4; expected auto direction
// follows SHIFT_SEQ_BOUNCE_EN.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic reset, lp, rp, lb, rb, auto_en, ovr;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    shift_seq_if cif ();

    shift_sequencer #(
        .WIDTH    (8),
        .TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .left_push  (lp),
        .right_push (rp),
        .left_bit   (lb),
        .right_bit  (rb),
        .auto_en    (auto_en),
        .overrun    (ovr),
        .cmd_if     (cif)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {valid, dir, bit, overrun}; dir/bit only meaningful while valid
    function automatic logic [3:0] obs();
        return {cif.cmd_valid, cif.cmd_valid & cif.cmd_dir,
                cif.cmd_valid & cif.cmd_bit, ovr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    initial begin
        int  lat;
        logic exp_dir, exp_bit;
        reset = 1'b1; lp = 0; rp = 0; lb = 0; rb = 0; auto_en = 0;
        cif.cmd_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("reset", obs(), 4'b0000);

        // single left shift
        lp = 1; lb = 1; step(); lp = 0; lb = 0;
        chk("L_basic", obs(), 4'b1010);
        step(); chk("L_once", obs(), 4'b0000);

        // reset mid-command with a pending left queued behind a held right
        cif.cmd_ready = 0;
        rp = 1; rb = 1; step(); rp = 0; rb = 0;
        chk("R_held", obs(), 4'b1110);
        lp = 1; lb = 0; step(); lp = 0;
        chk("R_hold2", obs(), 4'b1110);
        reset = 1; cif.cmd_ready = 1;
        repeat (3) step();
        chk("rst_mid", obs(), 4'b0000);
        reset = 0; step();
        chk("rst_pend_clear", obs(), 4'b0000);

        // simultaneous pushes: L first after reset, then R back-to-back
        lp = 1; lb = 0; rp = 1; rb = 1; step(); lp = 0; rp = 0;
        chk("rr1_L", obs(), 4'b1000);
        step(); chk("rr1_R", obs(), 4'b1110);
        step(); chk("rr1_idle", obs(), 4'b0000);

        // second tie after R last: L again; held while ready low
        cif.cmd_ready = 0;
        lp = 1; lb = 1; rp = 1; rb = 0; step(); lp = 0; rp = 0;
        chk("rr2_L", obs(), 4'b1010);
        step(); chk("rr2_hold", obs(), 4'b1010);
        cif.cmd_ready = 1; step();
        chk("rr2_R", obs(), 4'b1100);
        step(); chk("rr2_idle", obs(), 4'b0000);

        // overrun: second left push while first is still pending
        cif.cmd_ready = 0;
        rp = 1; rb = 0; step(); rp = 0;
        chk("ov_R", obs(), 4'b1100);
        lp = 1; lb = 1; step();
        chk("ov_p1", obs(), 4'b1100);
        lb = 0; step(); lp = 0;
        chk("ov_flag", obs(), 4'b1101);
        step(); chk("ov_pulse", obs(), 4'b1100);
        cif.cmd_ready = 1; step();
        chk("ov_L", obs(), 4'b1010);
        step(); chk("ov_single", obs(), 4'b0000);

        // auto walk: 16 steps, latency 5 then every 4 clocks
        auto_en = 1;
        for (int k = 0; k < 16; k++) begin
            lat = 0;
            do begin
                step();
                lat++;
            end while (!cif.cmd_valid && lat < 12);
            chk(k == 0 ? "auto_lat" : "auto_gap", lat, k == 0 ? 5 : 4);
            exp_bit = ((k % 8) == 0);
`ifdef SHIFT_SEQ_BOUNCE_EN
            exp_dir = (k >= 8);
`else
            exp_dir = 1'b0;
`endif
            chk("auto_cmd", {cif.cmd_valid, cif.cmd_dir, cif.cmd_bit, ovr},
                {1'b1, exp_dir, exp_bit, 1'b0});
        end

        // right push on the auto tick cycle: R first, auto next
        repeat (3) step();
        rp = 1; rb = 1; step(); rp = 0; rb = 0;
        chk("ar_R", obs(), 4'b1110);
        step(); chk("ar_A", obs(), 4'b1010);
        auto_en = 0; step();
        chk("auto_off", obs(), 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
